traffic_light_ctrl_gen: RTL and testbench

Parametrised two-approach (A/B) traffic light controller with per-approach green time, green-flash, yellow and all-red clearance phases. Emits per-approach lamp vectors, binary remaining-seconds counts and two-char ASCII countdowns. The ASCII outputs feed directly into led_display_seg_ctrl assic_seg slots, which drive the hc595 path. Replaces the fixed 7/2/5 s controller; adds all-red clearance, zero-length phase skipping and night flashing mode.

---
 rtl/traffic_light_ctrl_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_traffic_light_ctrl_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_gen.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_gen
// Two-approach (A/B) traffic light controller. Each approach runs through
// steady green, green-flash, yellow and all-red clearance phases. Zero-length
// flash / all-red phases are skipped without spending a clock in them.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   night_mode (only with NIGHT_MODE_EN) forces flashing-yellow night mode
//   light_a/b  lamps {red,yellow,green} per approach
//   remain_a/b seconds left in the current colour group (binary)
//   ascii_a/b  {tens,ones} ASCII digits of remain_a/b
//   phase      current FSM state code (debug)
//
// Optional feature macro: NIGHT_MODE_EN (adds night_mode input and NIGHT state).
// -----------------------------------------------------------------------------
module traffic_light_ctrl_gen #(
  parameter int CLK_CYCLE = 27000000,
  parameter int GREEN_A_S = 5,
  parameter int GREEN_B_S = 5,
  parameter int FLASH_S   = 2,
  parameter int YELLOW_S  = 2,
  parameter int ALL_RED_S = 1
) (
  input  logic        clk,
  input  logic        rstn,
`ifdef NIGHT_MODE_EN
  input  logic        night_mode,
`endif
  output logic [2:0]  light_a,
  output logic [2:0]  light_b,
  output logic [6:0]  remain_a,
  output logic [6:0]  remain_b,
  output logic [15:0] ascii_a,
  output logic [15:0] ascii_b,
  output logic [3:0]  phase
);

  localparam int            PW       = $clog2(CLK_CYCLE);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_CYCLE - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_CYCLE / 2);

  // Red group of one approach spans both clearances plus the other's go/yellow.
  localparam int RED_A = ALL_RED_S + GREEN_B_S + FLASH_S + YELLOW_S + ALL_RED_S;
  localparam int RED_B = ALL_RED_S + GREEN_A_S + FLASH_S + YELLOW_S + ALL_RED_S;

  typedef enum logic [3:0] {
    G_A  = 4'd0,
    F_A  = 4'd1,
    Y_A  = 4'd2,
    AR_A = 4'd3,
    G_B  = 4'd4,
    F_B  = 4'd5,
    Y_B  = 4'd6,
    AR_B = 4'd7
`ifdef NIGHT_MODE_EN
    , NIGHT = 4'd8
`endif
  } state_t;

  state_t        st, nxt;
  logic          boot;
  logic [PW-1:0] pres;
  logic [5:0]    secs;
  logic          sec_tick, half, last_sec, enter;

  logic [2:0]    light_a_p0, light_b_p0;
  logic [6:0]    remain_a_p0, remain_b_p0;
  logic [15:0]   ascii_a_p0, ascii_b_p0;

  function automatic logic [5:0] dur(input state_t s);
    case (s)
      G_A:        return 6'(GREEN_A_S);
      G_B:        return 6'(GREEN_B_S);
      F_A, F_B:   return 6'(FLASH_S);
      Y_A, Y_B:   return 6'(YELLOW_S);
      AR_A, AR_B: return 6'(ALL_RED_S);
      default:    return 6'd0;
    endcase
  endfunction

  // Successor in the normal cycle, hopping over zero-length phases.
  function automatic state_t succ(input state_t s);
    case (s)
      G_A:     return (FLASH_S != 0) ? F_A : Y_A;
      F_A:     return Y_A;
      Y_A:     return (ALL_RED_S != 0) ? AR_A : G_B;
      AR_A:    return G_B;
      G_B:     return (FLASH_S != 0) ? F_B : Y_B;
      F_B:     return Y_B;
      Y_B:     return (ALL_RED_S != 0) ? AR_B : G_A;
      default: return G_A;
    endcase
  endfunction

  // Seconds remaining in A's colour group at entry to each phase.
  function automatic logic [6:0] rem_a0(input state_t s);
    case (s)
      G_A:     return 7'(GREEN_A_S + FLASH_S);
      F_A:     return 7'(FLASH_S);
      Y_A:     return 7'(YELLOW_S);
      AR_A:    return 7'(RED_A);
      G_B:     return 7'(RED_A - ALL_RED_S);
      F_B:     return 7'(FLASH_S + YELLOW_S + ALL_RED_S);
      Y_B:     return 7'(YELLOW_S + ALL_RED_S);
      AR_B:    return 7'(ALL_RED_S);
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] rem_b0(input state_t s);
    case (s)
      G_B:     return 7'(GREEN_B_S + FLASH_S);
      F_B:     return 7'(FLASH_S);
      Y_B:     return 7'(YELLOW_S);
      AR_B:    return 7'(RED_B);
      G_A:     return 7'(RED_B - ALL_RED_S);
      F_A:     return 7'(FLASH_S + YELLOW_S + ALL_RED_S);
      Y_A:     return 7'(YELLOW_S + ALL_RED_S);
      AR_A:    return 7'(ALL_RED_S);
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [15:0] to_ascii(input logic [6:0] v);
    logic [6:0] t, o;
    t = v / 7'd10;
    o = v % 7'd10;
    return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, o}};
  endfunction

  assign sec_tick = (pres == PRE_MAX);
  assign half     = (pres >= PRE_HALF);
  assign last_sec = (secs == dur(st) - 6'd1);
  assign enter    = (nxt != st);
  assign phase    = st;

  always_comb begin
    nxt = st;
    if (boot)
      nxt = G_A;
    else if (sec_tick && last_sec)
      nxt = succ(st);
`ifdef NIGHT_MODE_EN
    if (night_mode)
      nxt = NIGHT;
    else if (st == NIGHT)
      nxt = (ALL_RED_S != 0) ? AR_B : G_A;
`endif
  end

  // Timebase restarts on every phase entry so each phase is whole seconds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st   <= AR_B;
      boot <= 1'b1;
      pres <= '0;
      secs <= '0;
    end else begin
      st   <= nxt;
      boot <= 1'b0;
      if (enter) begin
        pres <= '0;
        secs <= '0;
      end else if (sec_tick) begin
        pres <= '0;
        secs <= secs + 6'd1;
      end else begin
        pres <= pres + 1'b1;
      end
    end
  end

  // Stage p0: combinational output decode from current state/timebase
  always_comb begin
    light_a_p0  = 3'b100;
    light_b_p0  = 3'b100;
    remain_a_p0 = rem_a0(st) - {1'b0, secs};
    remain_b_p0 = rem_b0(st) - {1'b0, secs};
    case (st)
      G_A:     light_a_p0 = 3'b001;
      F_A:     light_a_p0 = {2'b00, half};
      Y_A:     light_a_p0 = 3'b010;
      G_B:     light_b_p0 = 3'b001;
      F_B:     light_b_p0 = {2'b00, half};
      Y_B:     light_b_p0 = 3'b010;
`ifdef NIGHT_MODE_EN
      NIGHT: begin
        light_a_p0  = {1'b0, ~half, 1'b0};
        light_b_p0  = {1'b0, ~half, 1'b0};
        remain_a_p0 = 7'd0;
        remain_b_p0 = 7'd0;
      end
`endif
      default: ;
    endcase
    ascii_a_p0 = to_ascii(remain_a_p0);
    ascii_b_p0 = to_ascii(remain_b_p0);
`ifdef NIGHT_MODE_EN
    if (st == NIGHT) begin
      ascii_a_p0 = 16'h2D2D;
      ascii_b_p0 = 16'h2D2D;
    end
`endif
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      light_a  <= 3'b100;
      light_b  <= 3'b100;
      remain_a <= 7'd0;
      remain_b <= 7'd0;
      ascii_a  <= 16'h3030;
      ascii_b  <= 16'h3030;
    end else begin
      light_a  <= light_a_p0;
      light_b  <= light_b_p0;
      remain_a <= remain_a_p0;
      remain_b <= remain_b_p0;
      ascii_a  <= ascii_a_p0;
      ascii_b  <= ascii_b_p0;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl_gen.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_ctrl_gen
// Scoreboard bench for traffic_light_ctrl_gen. Two instances share clk/rstn:
//   dut   : CLK_CYCLE=10, GREEN_A=5, GREEN_B=4, FLASH=3, YELLOW=2, ALL_RED=1
//   dut_v : same but FLASH=0, ALL_RED=0 (skipped phases)
// Expected values are tagged with the clock count since reset release and
// queued by the stimulus process; the monitor compares on each falling edge.
// Field ids: 0 phase,1 light_a,2 light_b,3 remain_a,4 remain_b,5 ascii_a,
// 6 ascii_b for dut; add 7 for dut_v.
// -----------------------------------------------------------------------------
module tb_traffic_light_ctrl_gen;

  logic        clk = 1'b0;
  logic        rstn;
`ifdef NIGHT_MODE_EN
  logic        night_mode;
`endif
  logic [2:0]  la1, lb1, la2, lb2;
  logic [6:0]  ra1, rb1, ra2, rb2;
  logic [15:0] aa1, ab1, aa2, ab2;
  logic [3:0]  ph1, ph2;

  always #5 clk = ~clk;

  traffic_light_ctrl_gen #(
    .CLK_CYCLE(10), .GREEN_A_S(5), .GREEN_B_S(4),
    .FLASH_S(3), .YELLOW_S(2), .ALL_RED_S(1)
  ) dut (
    .clk(clk), .rstn(rstn),
`ifdef NIGHT_MODE_EN
    .night_mode(night_mode),
`endif
    .light_a(la1), .light_b(lb1), .remain_a(ra1), .remain_b(rb1),
    .ascii_a(aa1), .ascii_b(ab1), .phase(ph1)
  );

  traffic_light_ctrl_gen #(
    .CLK_CYCLE(10), .GREEN_A_S(5), .GREEN_B_S(4),
    .FLASH_S(0), .YELLOW_S(2), .ALL_RED_S(0)
  ) dut_v (
    .clk(clk), .rstn(rstn),
`ifdef NIGHT_MODE_EN
    .night_mode(night_mode),
`endif
    .light_a(la2), .light_b(lb2), .remain_a(ra2), .remain_b(rb2),
    .ascii_a(aa2), .ascii_b(ab2), .phase(ph2)
  );

  typedef struct {
    int          cyc;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drain = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [15:0] dut_val(input int f);
    case (f)
      0:  return {12'd0, ph1};
      1:  return {13'd0, la1};
      2:  return {13'd0, lb1};
      3:  return {9'd0, ra1};
      4:  return {9'd0, rb1};
      5:  return aa1;
      6:  return ab1;
      7:  return {12'd0, ph2};
      8:  return {13'd0, la2};
      9:  return {13'd0, lb2};
      10: return {9'd0, ra2};
      11: return {9'd0, rb2};
      12: return aa2;
      13: return ab2;
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic string fname(input int f);
    string base;
    case (f % 7)
      0: base = "phase";
      1: base = "light_a";
      2: base = "light_b";
      3: base = "remain_a";
      4: base = "remain_b";
      5: base = "ascii_a";
      default: base = "ascii_b";
    endcase
    return (f >= 7) ? {"dut_v.", base} : {"dut.", base};
  endfunction

  function automatic logic [15:0] asc(input int r);
    return {8'h30 + 8'(r / 10), 8'h30 + 8'(r % 10)};
  endfunction

  // Monitor: compare every queued expectation whose cycle has come up.
  always @(negedge clk) begin
    int c_add, b_add;
    logic [15:0] got;
    c_add = 0;
    b_add = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (drain || sb[i].cyc < cyc) begin
        c_add++;
        b_add++;
        $display("FAIL %s @cyc %0d: not sampled (now cyc %0d), required %h",
                 fname(sb[i].fld), sb[i].cyc, cyc, sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc == cyc) begin
        c_add++;
        got = dut_val(sb[i].fld);
        if (got !== sb[i].val) begin
          b_add++;
          $display("FAIL %s @cyc %0d: got %h, required %h",
                   fname(sb[i].fld), cyc, got, sb[i].val);
        end
        sb.delete(i);
      end
    end
    n_cmp <= n_cmp + c_add;
    n_bad <= n_bad + b_add;
  end

  task automatic push(input int c, input int f, input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_reset(input int d);
    push(0, d + 0, 16'd7);
    push(0, d + 1, 16'b100);
    push(0, d + 2, 16'b100);
    push(0, d + 3, 16'd0);
    push(0, d + 4, 16'd0);
    push(0, d + 5, 16'h3030);
    push(0, d + 6, 16'h3030);
  endtask

  // One phase: s = first output cycle (entry + 1), n seconds, phase code,
  // starting remain values, steady lamps, and whether A/B green flashes.
  task automatic push_seg(input int d, input int s, input int n, input int ph,
                          input int ra0, input int rb0,
                          input logic [2:0] la, input logic [2:0] lb,
                          input bit fa, input bit fb);
    logic [2:0] v;
    push(s - 1, d + 0, 16'(ph));
    push(s + 10 * n - 2, d + 0, 16'(ph));
    for (int j = 0; j < n; j++) begin
      push(s + 10 * j,     d + 3, 16'(ra0 - j));
      push(s + 10 * j + 9, d + 3, 16'(ra0 - j));
      push(s + 10 * j,     d + 4, 16'(rb0 - j));
      push(s + 10 * j + 9, d + 4, 16'(rb0 - j));
      push(s + 10 * j + 5, d + 5, asc(ra0 - j));
      push(s + 10 * j + 5, d + 6, asc(rb0 - j));
    end
    for (int c = s; c < s + 10 * n; c++) begin
      v = fa ? {2'b00, ((c - s) % 10 >= 5)} : la;
      push(c, d + 1, {13'd0, v});
      v = fb ? {2'b00, ((c - s) % 10 >= 5)} : lb;
      push(c, d + 2, {13'd0, v});
    end
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  initial begin
    rstn = 1'b1;
`ifdef NIGHT_MODE_EN
    night_mode = 1'b0;
`endif
    #1 rstn = 1'b0;
    push_reset(0);
    push_reset(7);

    // Run 1: full cycle on dut, 130-clock cycle on dut_v
    push(2, 5, 16'h3038);
    push(102, 5, 16'h3131);
    push(202, 6, 16'h3132);
    push_seg(0,   2, 5, 0,  8, 11, 3'b001, 3'b100, 1'b0, 1'b0);
    push_seg(0,  52, 3, 1,  3,  6, 3'b000, 3'b100, 1'b1, 1'b0);
    push_seg(0,  82, 2, 2,  2,  3, 3'b010, 3'b100, 1'b0, 1'b0);
    push_seg(0, 102, 1, 3, 11,  1, 3'b100, 3'b100, 1'b0, 1'b0);
    push_seg(0, 112, 4, 4, 10,  7, 3'b100, 3'b001, 1'b0, 1'b0);
    push_seg(0, 152, 3, 5,  6,  3, 3'b100, 3'b000, 1'b0, 1'b1);
    push_seg(0, 182, 2, 6,  3,  2, 3'b100, 3'b010, 1'b0, 1'b0);
    push_seg(0, 202, 1, 7,  1, 12, 3'b100, 3'b100, 1'b0, 1'b0);
    push_seg(0, 212, 5, 0,  8, 11, 3'b001, 3'b100, 1'b0, 1'b0);
    push_seg(7,   2, 5, 0,  5,  7, 3'b001, 3'b100, 1'b0, 1'b0);
    push_seg(7,  52, 2, 2,  2,  2, 3'b010, 3'b100, 1'b0, 1'b0);
    push_seg(7,  72, 4, 4,  6,  4, 3'b100, 3'b001, 1'b0, 1'b0);
    push_seg(7, 112, 2, 6,  2,  2, 3'b100, 3'b010, 1'b0, 1'b0);
    push_seg(7, 132, 5, 0,  5,  7, 3'b001, 3'b100, 1'b0, 1'b0);
    push(394, 0, 16'd6);
    push(394, 2, 16'b010);

    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // Reset mid Y_B of the second cycle
    wait_cyc(395);
    #1 rstn = 1'b0;
    push_reset(0);
    push_reset(7);
    repeat (2) @(posedge clk);

    // Run 2: restart identical to run 1
    push(2, 5, 16'h3038);
    push_seg(0,  2, 5, 0, 8, 11, 3'b001, 3'b100, 1'b0, 1'b0);
    push_seg(0, 52, 3, 1, 3,  6, 3'b000, 3'b100, 1'b1, 1'b0);
    push_seg(7,  2, 5, 0, 5,  7, 3'b001, 3'b100, 1'b0, 1'b0);
    #2 rstn = 1'b1;

`ifdef NIGHT_MODE_EN
    for (int c = 122; c <= 141; c++) begin
      logic [2:0] lv;
      lv = {1'b0, ((c - 122) % 10 < 5), 1'b0};
      push(c, 1, {13'd0, lv});
      push(c, 2, {13'd0, lv});
      push(c, 8, {13'd0, lv});
      push(c, 9, {13'd0, lv});
    end
    for (int k = 0; k < 2; k++) begin
      push(121, 7 * k + 0, 16'd8);
      push(140, 7 * k + 0, 16'd8);
      push(122, 7 * k + 3, 16'd0);
      push(122, 7 * k + 4, 16'd0);
      push(122, 7 * k + 5, 16'h2D2D);
      push(141, 7 * k + 6, 16'h2D2D);
    end
    push(141, 0, 16'd7);
    push(150, 0, 16'd7);
    push(151, 0, 16'd0);
    push(142, 1, 16'b100);
    push(142, 2, 16'b100);
    push(142, 3, 16'd1);
    push(142, 4, 16'd12);
    push(152, 1, 16'b001);
    push(152, 3, 16'd8);
    push(152, 5, 16'h3038);
    push(141, 7, 16'd0);
    push(142, 8, 16'b001);
    push(142, 10, 16'd5);
    push(142, 11, 16'd7);
    wait_cyc(120);
    #1 night_mode = 1'b1;
    wait_cyc(140);
    #1 night_mode = 1'b0;
    wait_cyc(160);
`else
    wait_cyc(100);
`endif

    #1 drain = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
